adc_clk_en_gen: RTL and testbench

- Parametrised, fully synchronous successor to the single-output ADC clock wrapper.
- Runs from the fabric reference clock and produces NUM_CLOCKS derived clock-enable waveforms (level plus period strobe).
- Divide ratio, high time and phase are programmable per channel at run time; a realign command re-phases all channels together; lock qualification is emulated.
- Sits between the board oscillator and the ADC sampling/serialiser logic.

---
 rtl/adc_clk_pkg.sv | 28 ++
 rtl/adc_clk_en_gen_if.sv | 25 ++
 rtl/adc_clk_en_chan.sv | 84 ++++++++
 rtl/adc_clk_en_gen.sv | 106 ++++++++++
 tb/tb_adc_clk_en_gen.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_clk_pkg.sv
// rtl/adc_clk_pkg.sv - shared types and defaults for the ADC clock-enable generator
package adc_clk_pkg;

  localparam int DFLT_DIV_W       = 16;
  localparam int DFLT_DIV         = 4;
  localparam int DFLT_HIGH        = 2;
  localparam int DFLT_LOCK_CYCLES = 1024;

  typedef struct packed {
    logic [DFLT_DIV_W-1:0] div;
    logic [DFLT_DIV_W-1:0] high;
    logic [DFLT_DIV_W-1:0] phase;
  } chan_cfg_t;

  typedef enum logic {
    LOCK_WAIT   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_t;

  // A phase outside the period would leave the counter beyond its wrap point.
  function automatic chan_cfg_t clamp_phase(input chan_cfg_t c);
    chan_cfg_t r;
    r = c;
    if (r.phase >= r.div) r.phase = '0;
    return r;
  endfunction

endpackage

// File: rtl/adc_clk_en_gen_if.sv
// rtl/adc_clk_en_gen_if.sv - configuration and realign bus for the clock-enable generator
interface adc_clk_en_gen_if #(
  parameter int CH_W  = 2,
  parameter int DIV_W = 16
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_high;
  logic [DIV_W-1:0] cfg_phase;
  logic             realign;

  modport master (
    output cfg_valid, cfg_chan, cfg_div, cfg_high, cfg_phase, realign,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_div, cfg_high, cfg_phase, realign,
    output cfg_ready
  );

endinterface

// File: rtl/adc_clk_en_chan.sv
// rtl/adc_clk_en_chan.sv - one divided clock-enable channel with shadowed configuration
module adc_clk_en_chan
  import adc_clk_pkg::*;
#(
  parameter int DEF_DIV  = DFLT_DIV,
  parameter int DEF_HIGH = DFLT_HIGH
) (
  input  logic      refclk,
  input  logic      rst,
  input  logic      wr_en,
  input  chan_cfg_t wr_cfg,
  input  logic      realign,
  output logic      pending,
  output logic      level,
  output logic      stb
);

  localparam chan_cfg_t RST_CFG = '{
    div:   DFLT_DIV_W'(DEF_DIV),
    high:  DFLT_DIV_W'(DEF_HIGH),
    phase: '0
  };
  localparam logic [DFLT_DIV_W-1:0] ONE = DFLT_DIV_W'(1);

  chan_cfg_t             active_q;
  chan_cfg_t             shadow_q;
  logic [DFLT_DIV_W-1:0] cnt_q;
  logic                  pending_q;
  logic                  level_q;
  logic                  stb_q;

  logic                  enabled;
  logic                  wrap;
  logic                  apply;
  chan_cfg_t             next_cfg;
  logic [DFLT_DIV_W-1:0] reload_phase;

  // Decide whether a new config lands this cycle and where realign restarts the counter.
  always_comb begin
    enabled      = (active_q.div != '0);
    wrap         = !enabled || (cnt_q == active_q.div - ONE);
    apply        = 1'b0;
    next_cfg     = clamp_phase(shadow_q);
    if (realign) begin
      // A config accepted alongside realign bypasses the shadow so the reload uses it.
      apply    = wr_en || pending_q;
      next_cfg = clamp_phase(wr_en ? wr_cfg : shadow_q);
    end else begin
      apply    = pending_q && wrap;
    end
    reload_phase = apply ? next_cfg.phase : active_q.phase;
  end

  // Counter, shadow/active registers and registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      active_q  <= RST_CFG;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      level_q   <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      level_q <= enabled && (cnt_q < active_q.high);
      stb_q   <= enabled && (cnt_q == '0);

      if (apply) active_q <= next_cfg;
      if (wr_en) shadow_q <= wr_cfg;

      if (realign)   pending_q <= 1'b0;
      else if (wr_en) pending_q <= 1'b1;
      else if (apply) pending_q <= 1'b0;

      if (realign)   cnt_q <= reload_phase;
      else if (wrap) cnt_q <= '0;
      else           cnt_q <= cnt_q + ONE;
    end
  end

  assign pending = pending_q;
  assign level   = level_q;
  assign stb     = stb_q;

endmodule

// File: rtl/adc_clk_en_gen.sv
// rtl/adc_clk_en_gen.sv - multi-channel ADC clock-enable generator with emulated lock
module adc_clk_en_gen
  import adc_clk_pkg::*;
#(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_W       = DFLT_DIV_W,
  parameter int CH_W        = 2,
  parameter int DEF_DIV     = DFLT_DIV,
  parameter int DEF_HIGH    = DFLT_HIGH,
  parameter int LOCK_CYCLES = DFLT_LOCK_CYCLES
) (
  input  logic                  refclk,
  input  logic                  rst,
  adc_clk_en_gen_if.slave       bus,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_stb,
  output logic                  locked
);

  localparam int         LC_W    = $clog2(LOCK_CYCLES);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(LOCK_CYCLES - 1);

  logic [NUM_CLOCKS-1:0] pending;
  logic [NUM_CLOCKS-1:0] level;
  logic [NUM_CLOCKS-1:0] stb;
  logic [2**CH_W-1:0]    pend_full;
  logic                  accept;
  logic [DIV_W-1:0]      div_in;
  logic [DIV_W-1:0]      high_in;
  logic [DIV_W-1:0]      phase_in;
  chan_cfg_t             wr_cfg;

  lock_state_t           state_q;
  lock_state_t           state_d;
  logic [LC_W-1:0]       lock_cnt_q;
  logic [LC_W-1:0]       lock_cnt_d;

  // Unused channel slots read as never pending, so out-of-range requests are taken and dropped.
  always_comb begin
    pend_full                 = '0;
    pend_full[NUM_CLOCKS-1:0] = pending;
  end

  assign bus.cfg_ready = ~pend_full[bus.cfg_chan];
  assign accept        = bus.cfg_valid & bus.cfg_ready;
  assign div_in        = bus.cfg_div;
  assign high_in       = bus.cfg_high;
  assign phase_in      = bus.cfg_phase;

  // Pack the request fields into the per-channel config record.
  always_comb begin
    wr_cfg.div   = DFLT_DIV_W'(div_in);
    wr_cfg.high  = DFLT_DIV_W'(high_in);
    wr_cfg.phase = DFLT_DIV_W'(phase_in);
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    adc_clk_en_chan #(
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH)
    ) u_chan (
      .refclk  (refclk),
      .rst     (rst),
      .wr_en   (accept && (bus.cfg_chan == CH_W'(i))),
      .wr_cfg  (wr_cfg),
      .realign (bus.realign),
      .pending (pending[i]),
      .level   (level[i]),
      .stb     (stb[i])
    );
  end

  // Lock FSM state and settle counter.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= LOCK_WAIT;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Lock FSM next state: settle for LOCK_CYCLES, restart on realign.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      LOCK_WAIT: begin
        if (lock_cnt_q == LC_LAST) state_d = LOCK_LOCKED;
        else                       lock_cnt_d = lock_cnt_q + LC_W'(1);
      end
      LOCK_LOCKED: state_d = LOCK_LOCKED;
      default:     state_d = LOCK_WAIT;
    endcase
    if (bus.realign) begin
      state_d    = LOCK_WAIT;
      lock_cnt_d = '0;
    end
  end

  assign locked     = (state_q == LOCK_LOCKED);
  assign outclk     = level & {NUM_CLOCKS{locked}};
  assign outclk_stb = stb & {NUM_CLOCKS{locked}};

endmodule

// File: tb/tb_adc_clk_en_gen.sv
// tb/tb_adc_clk_en_gen.sv - randomized self-checking bench for adc_clk_en_gen
module tb_adc_clk_en_gen;

  localparam int NC    = 3;
  localparam int CH_W  = 2;
  localparam int DIV_W = 16;
  localparam int LC    = 16;

  logic          refclk = 1'b0;
  logic          rst    = 1'b1;
  logic [NC-1:0] outclk;
  logic [NC-1:0] outclk_stb;
  logic          locked;

  adc_clk_en_gen_if #(.CH_W(CH_W), .DIV_W(DIV_W)) bus ();

  adc_clk_en_gen #(
    .NUM_CLOCKS  (NC),
    .DIV_W       (DIV_W),
    .CH_W        (CH_W),
    .DEF_DIV     (4),
    .DEF_HIGH    (2),
    .LOCK_CYCLES (LC)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .bus        (bus),
    .outclk     (outclk),
    .outclk_stb (outclk_stb),
    .locked     (locked)
  );

  always #5 refclk = ~refclk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel's count is the cycles elapsed since its epoch, modulo its period.
  int n;
  int lock_start;
  int a_div[NC], a_high[NC], a_phase[NC], epoch[NC];
  int s_div[NC], s_high[NC], s_phase[NC];
  bit pend[NC];
  bit raw_lvl[NC], raw_stb[NC];

  function automatic int cnt_at(input int ch, input int m);
    if (a_div[ch] == 0) return 0;
    return (m - epoch[ch]) % a_div[ch];
  endfunction

  function automatic bit pend_at(input int c);
    if (c >= NC) return 1'b0;
    return pend[c];
  endfunction

  task automatic load(input int ch, input int d, input int h, input int p);
    a_div[ch]   = d;
    a_high[ch]  = h;
    a_phase[ch] = (p >= d) ? 0 : p;
  endtask

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      n = 0;
      lock_start = 0;
      for (int ch = 0; ch < NC; ch++) begin
        a_div[ch] = 4; a_high[ch] = 2; a_phase[ch] = 0; epoch[ch] = 0;
        pend[ch] = 1'b0; raw_lvl[ch] = 1'b0; raw_stb[ch] = 1'b0;
        s_div[ch] = 0; s_high[ch] = 0; s_phase[ch] = 0;
      end
    end else begin
      int  c[NC];
      int  ci;
      bit  acc;
      bit  ra;
      bit  wrap;
      ci  = int'(bus.cfg_chan);
      ra  = bus.realign;
      acc = bus.cfg_valid && !pend_at(ci);
      for (int ch = 0; ch < NC; ch++) begin
        c[ch]       = cnt_at(ch, n);
        raw_lvl[ch] = (a_div[ch] > 0) && (c[ch] < a_high[ch]);
        raw_stb[ch] = (a_div[ch] > 0) && (c[ch] == 0);
      end
      n++;
      for (int ch = 0; ch < NC; ch++) begin
        wrap = (a_div[ch] == 0) || (c[ch] == a_div[ch] - 1);
        if (ra) begin
          if (acc && ci == ch) load(ch, int'(bus.cfg_div), int'(bus.cfg_high), int'(bus.cfg_phase));
          else if (pend[ch])   load(ch, s_div[ch], s_high[ch], s_phase[ch]);
          pend[ch]  = 1'b0;
          epoch[ch] = n - a_phase[ch];
        end else begin
          if (pend[ch] && wrap) begin
            load(ch, s_div[ch], s_high[ch], s_phase[ch]);
            pend[ch]  = 1'b0;
            epoch[ch] = n;
          end
          if (acc && ci == ch) begin
            s_div[ch]   = int'(bus.cfg_div);
            s_high[ch]  = int'(bus.cfg_high);
            s_phase[ch] = int'(bus.cfg_phase);
            pend[ch]    = 1'b1;
          end
        end
      end
      if (ra) lock_start = n;
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the active edge.
  logic [NC-1:0] exp_lvl, exp_stb;
  logic          exp_lk, exp_rdy;
  always @(negedge refclk) begin
    exp_lk = (n - lock_start >= LC);
    for (int ch = 0; ch < NC; ch++) begin
      exp_lvl[ch] = raw_lvl[ch] && exp_lk;
      exp_stb[ch] = raw_stb[ch] && exp_lk;
    end
    exp_rdy = !pend_at(int'(bus.cfg_chan));
    check("model_outclk",    32'(outclk),        32'(exp_lvl));
    check("model_outclk_stb", 32'(outclk_stb),   32'(exp_stb));
    check("model_locked",    32'(locked),        32'(exp_lk));
    check("model_cfg_ready", 32'(bus.cfg_ready), 32'(exp_rdy));
  end

  task automatic tick(input int k);
    repeat (k) @(posedge refclk);
    #2;
  endtask

  task automatic cfg_write(input int ch, input int d, input int h, input int p, output int stall);
    int k;
    k = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_chan  = CH_W'(ch);
    bus.cfg_div   = DIV_W'(d);
    bus.cfg_high  = DIV_W'(h);
    bus.cfg_phase = DIV_W'(p);
    #1;
    while (!bus.cfg_ready && k < 64) begin
      @(posedge refclk);
      #1;
      k++;
    end
    compared++;
    if (k >= 64) begin
      mismatched++;
      $display("FAIL cfg_write_timeout: chan %0d still not ready after %0d cycles", ch, k);
    end
    @(posedge refclk);
    #2;
    bus.cfg_valid = 1'b0;
    stall = k;
  endtask

  initial begin
    int st;
    int r;
    bus.cfg_valid = 1'b0;
    bus.cfg_chan  = '0;
    bus.cfg_div   = '0;
    bus.cfg_high  = '0;
    bus.cfg_phase = '0;
    bus.realign   = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge refclk);
    #1;
    check("rst_outclk", 32'(outclk), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_ready",  32'(bus.cfg_ready), 32'd1);
    #1;
    rst = 1'b0;

    // Lock after 16 cycles, then the default 1100 pattern on all channels.
    tick(15);
    check("lock_n15", 32'(locked), 32'd0);
    tick(1);
    check("lock_n16", 32'(locked), 32'd1);
    check("clk_n16",  32'(outclk), 32'd0);
    tick(1);
    check("clk_n17",  32'(outclk), 32'h7);
    check("stb_n17",  32'(outclk_stb), 32'h7);
    tick(1);
    check("clk_n18",  32'(outclk), 32'h7);
    check("stb_n18",  32'(outclk_stb), 32'h0);
    tick(1);
    check("clk_n19",  32'(outclk), 32'h0);
    tick(2);

    // ch1 {5,1,0} accepted at n=22, applied on the wrap at n=24.
    cfg_write(1, 5, 1, 0, st);
    check("ch1_ready_pending", 32'(bus.cfg_ready), 32'd0);
    tick(1);
    check("ch1_ready_n23", 32'(bus.cfg_ready), 32'd0);
    tick(1);
    check("ch1_ready_applied", 32'(bus.cfg_ready), 32'd1);
    tick(1);
    check("ch1_first_high", 32'(outclk[1]), 32'd1);
    check("ch1_first_stb",  32'(outclk_stb[1]), 32'd1);
    tick(1);
    check("ch1_low", 32'(outclk[1]), 32'd0);
    tick(4);
    check("ch1_second_high", 32'(outclk[1]), 32'd1);

    // ch2 {6,3,2} then realign: relock after 16 cycles with ch2 offset by its phase.
    cfg_write(2, 6, 3, 2, st);
    bus.realign = 1'b1;
    tick(1);
    bus.realign = 1'b0;
    check("realign_unlock", 32'(locked), 32'd0);
    tick(15);
    check("realign_n15", 32'(locked), 32'd0);
    tick(1);
    check("realign_n16", 32'(locked), 32'd1);
    tick(1);
    check("realign_clk", 32'(outclk), 32'h5);
    check("realign_stb", 32'(outclk_stb), 32'h5);

    // Disable ch2, then re-enable with high >= div.
    cfg_write(2, 0, 0, 0, st);
    tick(10);
    check("ch2_off_clk", 32'(outclk[2]), 32'd0);
    check("ch2_off_stb", 32'(outclk_stb[2]), 32'd0);
    cfg_write(2, 3, 5, 0, st);
    tick(2);
    check("ch2_on_clk", 32'(outclk[2]), 32'd1);
    check("ch2_on_stb", 32'(outclk_stb[2]), 32'd1);
    tick(1);
    check("ch2_on_clk2", 32'(outclk[2]), 32'd1);
    check("ch2_on_stb2", 32'(outclk_stb[2]), 32'd0);

    // Back-to-back writes to ch0 stall; out-of-range channel is taken and dropped.
    cfg_write(0, 5, 2, 0, st);
    check("b2b_ready_low", 32'(bus.cfg_ready), 32'd0);
    cfg_write(0, 7, 3, 1, st);
    check("b2b_stalled", 32'(st > 0), 32'd1);
    bus.cfg_chan = CH_W'(3);
    #1;
    check("chan3_ready", 32'(bus.cfg_ready), 32'd1);
    #1;
    cfg_write(3, 2, 1, 0, st);

    // Config accept coinciding with realign on ch1.
    tick(12);
    bus.cfg_valid = 1'b1;
    bus.cfg_chan  = CH_W'(1);
    bus.cfg_div   = DIV_W'(3);
    bus.cfg_high  = DIV_W'(1);
    bus.cfg_phase = DIV_W'(2);
    bus.realign   = 1'b1;
    tick(1);
    bus.cfg_valid = 1'b0;
    bus.realign   = 1'b0;
    tick(20);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bus.cfg_valid = ($urandom_range(3) == 0);
      bus.cfg_chan  = CH_W'($urandom_range(3));
      bus.cfg_div   = DIV_W'($urandom_range(7));
      bus.cfg_high  = DIV_W'($urandom_range(8));
      bus.cfg_phase = DIV_W'($urandom_range(8));
      r = $urandom_range(199);
      bus.realign   = (r == 0);
      tick(1);
    end
    bus.cfg_valid = 1'b0;
    bus.realign   = 1'b0;
    tick(20);
    check("pre_rst_locked", 32'(locked), 32'd1);

    // Reset while locked: outputs clear at once, defaults resume afterwards.
    rst = 1'b1;
    #1;
    check("midrst_clk",    32'(outclk), 32'd0);
    check("midrst_stb",    32'(outclk_stb), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(16);
    check("relock_after_rst", 32'(locked), 32'd1);
    tick(1);
    check("rst_default_clk", 32'(outclk), 32'h7);
    check("rst_default_stb", 32'(outclk_stb), 32'h7);
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
